control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Pipelined consumer of the main decoder's per-opcode control bundle (BRANCH, MEMREAD, MEMTOREG, MEMWRITE, ALUSRC, REGWRITE, ALUOP, AUIPCLUI).
- Registers the bundle through the ID/EX, EX/MEM and MEM/WB stages of the 5-stage core.
- Detects load-use hazards and generates STALL.
- Squashes the ID-stage instruction on a taken branch.
- Produces EX-stage operand forwarding selects.

Parameters:
- TAM_ALUOP, 3, ALUOP width.
- TAM_AUIPCLUI, 2, AUIPCLUI width.
- TAM_REG, 5, register index width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- ID_BRANCH, ID_MEMREAD, ID_MEMTOREG, ID_MEMWRITE, ID_ALUSRC, ID_REGWRITE  input  1 each  decoder outputs for the ID instruction.
- ID_ALUOP  input  TAM_ALUOP  decoder ALUOP.
- ID_AUIPCLUI  input  TAM_AUIPCLUI  decoder AUIPCLUI.
- ID_RS1, ID_RS2, ID_RD  input  TAM_REG each  register fields of the ID instruction.
- ID_RS2_VALID  input  1  instruction reads rs2 (R, S, B formats).
- BRANCH_TAKEN  input  1  branch resolved taken in EX this cycle.
- STALL  output  1  hold PC and IF/ID.
- FLUSH  output  1  clear IF/ID.
- EX_BRANCH, EX_MEMREAD, EX_MEMTOREG, EX_MEMWRITE, EX_ALUSRC, EX_REGWRITE  output  1 each  ID/EX control.
- EX_ALUOP  output  TAM_ALUOP  ID/EX ALUOP.
- EX_AUIPCLUI  output  TAM_AUIPCLUI  ID/EX AUIPCLUI.
- EX_RS1, EX_RS2, EX_RD  output  TAM_REG each  ID/EX register fields.
- MEM_MEMREAD, MEM_MEMWRITE, MEM_MEMTOREG, MEM_REGWRITE  output  1 each  EX/MEM control.
- MEM_RD  output  TAM_REG  EX/MEM rd.
- WB_MEMTOREG, WB_REGWRITE  output  1 each  MEM/WB control.
- WB_RD  output  TAM_REG  MEM/WB rd.
- FWD_A, FWD_B  output  2 each  forwarding select for ALU operands A and B.

Behaviour:
- **Reset:** RST high at an edge loads all stage registers with a bubble.
  - Bubble = every 1-bit control 0, ALUOP 0, RS/RD 0, AUIPCLUI 2'b10.
  - Consequently STALL=0, FLUSH=0, FWD_A=FWD_B=2'b00.
  - RST overrides stall and flush.
- **Latency:** the ID bundle appears on EX_* 1 cycle after the edge, MEM_* after 2, WB_* after 3, absent stall or flush.
- **Load-use detection (combinational):**
  - HAZ = EX_MEMREAD & (EX_RD != 0) & ((EX_RD == ID_RS1) | (ID_RS2_VALID & (EX_RD == ID_RS2))).
  - STALL = HAZ & ~BRANCH_TAKEN.
- **FLUSH:** FLUSH = BRANCH_TAKEN.
- **ID/EX next value:** bubble if STALL or FLUSH; otherwise the ID inputs.
- **EX/MEM and MEM/WB:** always advance, never held or cleared except by reset. The load in EX therefore proceeds while the dependent instruction waits one cycle in ID.
- **Stall and branch taken in the same cycle:** flush wins.
  - STALL=0, FLUSH=1, ID/EX gets a bubble.
  - The squashed instruction must not also be held.
- **Forwarding (combinational on registered state):**
  - FWD_A = 2'b10 if MEM_REGWRITE & MEM_RD != 0 & MEM_RD == EX_RS1.
  - Else FWD_A = 2'b01 if WB_REGWRITE & WB_RD != 0 & WB_RD == EX_RS1.
  - Else FWD_A = 2'b00.
  - FWD_B uses the same rule with EX_RS2.
  - MEM priority over WB. Register x0 is never forwarded.
- **AUIPCLUI:** passed through unchanged; only the bubble value 2'b10 is imposed.
- **No internal FSM** beyond the stage registers. Back-to-back stalls are allowed: each cycle HAZ is re-evaluated against the current EX contents.

Test Plan:
- **Reset:** hold RST 2 cycles with ID_REGWRITE=1, ID_RD=5 → all EX_/MEM_/WB_ controls 0, EX_AUIPCLUI=2'b10, STALL=FLUSH=0, FWD=00.
- **Propagation:** R-type bundle (REGWRITE=1, ALUOP=000, RD=7), no hazards → EX_REGWRITE=1/EX_RD=7 at cycle+1, MEM_RD=7 at +2, WB_REGWRITE=1/WB_RD=7 at +3.
- **Load-use stall:** lw x5 followed by add rs1=5 → STALL=1 for exactly 1 cycle, ID/EX bubble, next cycle EX_RS1=5 and FWD_A=2'b01 (load in WB).
- **Branch flush:** BRANCH_TAKEN=1 with a sw in ID → FLUSH=1, EX_MEMWRITE=0 next cycle.
- **Simultaneous stall and flush:** lw x3 in EX, rs2=3 in ID (RS2_VALID=1), BRANCH_TAKEN=1 → STALL=0, FLUSH=1, EX_* bubble.
- **Forwarding priority and x0:** MEM_RD=WB_RD=EX_RS1=4, both REGWRITE=1 → FWD_A=2'b10. All three fields =0 → FWD_A=2'b00.

Source files
------------

// File: rtl/control_pipe.sv
// Control bundle pipeline for ID/EX, EX/MEM and MEM/WB, with load-use stall, branch squash and EX forwarding selects.
// Latency: EX_* one edge after ID, MEM_* two, WB_* three. Backpressure: STALL holds PC/IF-ID while ID/EX takes a bubble.
module control_pipe #(
  parameter int TAM_ALUOP    = 3,
  parameter int TAM_AUIPCLUI = 2,
  parameter int TAM_REG      = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ID_BRANCH,
  input  logic                    ID_MEMREAD,
  input  logic                    ID_MEMTOREG,
  input  logic                    ID_MEMWRITE,
  input  logic                    ID_ALUSRC,
  input  logic                    ID_REGWRITE,
  input  logic [TAM_ALUOP-1:0]    ID_ALUOP,
  input  logic [TAM_AUIPCLUI-1:0] ID_AUIPCLUI,
  input  logic [TAM_REG-1:0]      ID_RS1,
  input  logic [TAM_REG-1:0]      ID_RS2,
  input  logic [TAM_REG-1:0]      ID_RD,
  input  logic                    ID_RS2_VALID,
  input  logic                    BRANCH_TAKEN,
  output logic                    STALL,
  output logic                    FLUSH,
  output logic                    EX_BRANCH,
  output logic                    EX_MEMREAD,
  output logic                    EX_MEMTOREG,
  output logic                    EX_MEMWRITE,
  output logic                    EX_ALUSRC,
  output logic                    EX_REGWRITE,
  output logic [TAM_ALUOP-1:0]    EX_ALUOP,
  output logic [TAM_AUIPCLUI-1:0] EX_AUIPCLUI,
  output logic [TAM_REG-1:0]      EX_RS1,
  output logic [TAM_REG-1:0]      EX_RS2,
  output logic [TAM_REG-1:0]      EX_RD,
  output logic                    MEM_MEMREAD,
  output logic                    MEM_MEMWRITE,
  output logic                    MEM_MEMTOREG,
  output logic                    MEM_REGWRITE,
  output logic [TAM_REG-1:0]      MEM_RD,
  output logic                    WB_MEMTOREG,
  output logic                    WB_REGWRITE,
  output logic [TAM_REG-1:0]      WB_RD,
  output logic [1:0]              FWD_A,
  output logic [1:0]              FWD_B
);

  typedef struct packed {
    logic                    branch;
    logic                    memread;
    logic                    memtoreg;
    logic                    memwrite;
    logic                    alusrc;
    logic                    regwrite;
    logic [TAM_ALUOP-1:0]    aluop;
    logic [TAM_AUIPCLUI-1:0] auipclui;
    logic [TAM_REG-1:0]      rs1;
    logic [TAM_REG-1:0]      rs2;
    logic [TAM_REG-1:0]      rd;
  } ex_t;

  typedef struct packed {
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regwrite;
    logic [TAM_REG-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic               memtoreg;
    logic               regwrite;
    logic [TAM_REG-1:0] rd;
  } wb_t;

  localparam logic [TAM_AUIPCLUI-1:0] AUIPCLUI_BUBBLE = TAM_AUIPCLUI'(2'b10);

  ex_t  ex_q, ex_d, id_bundle, ex_bubble;
  mem_t mem_q, mem_d;
  wb_t  wb_q, wb_d;
  logic haz;

  // A producer in MEM is younger than one in WB, so it must win.
  function automatic logic [1:0] fwd_sel(
    input logic [TAM_REG-1:0] rs,
    input mem_t               m,
    input wb_t                w
  );
    if (m.regwrite && m.rd != '0 && m.rd == rs)      return 2'b10;
    else if (w.regwrite && w.rd != '0 && w.rd == rs) return 2'b01;
    else                                             return 2'b00;
  endfunction

  always_comb begin
    ex_bubble          = '0;
    ex_bubble.auipclui = AUIPCLUI_BUBBLE;

    id_bundle.branch   = ID_BRANCH;
    id_bundle.memread  = ID_MEMREAD;
    id_bundle.memtoreg = ID_MEMTOREG;
    id_bundle.memwrite = ID_MEMWRITE;
    id_bundle.alusrc   = ID_ALUSRC;
    id_bundle.regwrite = ID_REGWRITE;
    id_bundle.aluop    = ID_ALUOP;
    id_bundle.auipclui = ID_AUIPCLUI;
    id_bundle.rs1      = ID_RS1;
    id_bundle.rs2      = ID_RS2;
    id_bundle.rd       = ID_RD;

    haz = ex_q.memread && (ex_q.rd != '0) &&
          ((ex_q.rd == ID_RS1) || (ID_RS2_VALID && (ex_q.rd == ID_RS2)));
    // A taken branch squashes the ID instruction, so holding it would be pointless.
    STALL = haz && !BRANCH_TAKEN;
    FLUSH = BRANCH_TAKEN;

    ex_d = (STALL || FLUSH) ? ex_bubble : id_bundle;

    mem_d.memread  = ex_q.memread;
    mem_d.memwrite = ex_q.memwrite;
    mem_d.memtoreg = ex_q.memtoreg;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.rd       = ex_q.rd;

    wb_d.memtoreg  = mem_q.memtoreg;
    wb_d.regwrite  = mem_q.regwrite;
    wb_d.rd        = mem_q.rd;

    FWD_A = fwd_sel(ex_q.rs1, mem_q, wb_q);
    FWD_B = fwd_sel(ex_q.rs2, mem_q, wb_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q  <= ex_bubble;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign EX_BRANCH    = ex_q.branch;
  assign EX_MEMREAD   = ex_q.memread;
  assign EX_MEMTOREG  = ex_q.memtoreg;
  assign EX_MEMWRITE  = ex_q.memwrite;
  assign EX_ALUSRC    = ex_q.alusrc;
  assign EX_REGWRITE  = ex_q.regwrite;
  assign EX_ALUOP     = ex_q.aluop;
  assign EX_AUIPCLUI  = ex_q.auipclui;
  assign EX_RS1       = ex_q.rs1;
  assign EX_RS2       = ex_q.rs2;
  assign EX_RD        = ex_q.rd;
  assign MEM_MEMREAD  = mem_q.memread;
  assign MEM_MEMWRITE = mem_q.memwrite;
  assign MEM_MEMTOREG = mem_q.memtoreg;
  assign MEM_REGWRITE = mem_q.regwrite;
  assign MEM_RD       = mem_q.rd;
  assign WB_MEMTOREG  = wb_q.memtoreg;
  assign WB_REGWRITE  = wb_q.regwrite;
  assign WB_RD        = wb_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// Randomised and directed stimulus for control_pipe, scored against an instruction-level pipeline model.
module tb_control_pipe;

  typedef struct packed {
    logic       br, mr, mt, mw, as, rw;
    logic [2:0] aluop;
    logic [1:0] au;
    logic [4:0] rs1, rs2, rd;
  } ctl_t;

  typedef struct packed {
    logic       stall, flush;
    logic [1:0] fa, fb;
    ctl_t       ex;
    logic [8:0] mem;
    logic [6:0] wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  ctl_t id_c;
  logic id_v, bt;

  logic STALL, FLUSH;
  logic EX_BRANCH, EX_MEMREAD, EX_MEMTOREG, EX_MEMWRITE, EX_ALUSRC, EX_REGWRITE;
  logic [2:0] EX_ALUOP;
  logic [1:0] EX_AUIPCLUI;
  logic [4:0] EX_RS1, EX_RS2, EX_RD;
  logic MEM_MEMREAD, MEM_MEMWRITE, MEM_MEMTOREG, MEM_REGWRITE;
  logic [4:0] MEM_RD;
  logic WB_MEMTOREG, WB_REGWRITE;
  logic [4:0] WB_RD;
  logic [1:0] FWD_A, FWD_B;

  control_pipe dut (
    .CLK(clk), .RST(rst),
    .ID_BRANCH(id_c.br), .ID_MEMREAD(id_c.mr), .ID_MEMTOREG(id_c.mt),
    .ID_MEMWRITE(id_c.mw), .ID_ALUSRC(id_c.as), .ID_REGWRITE(id_c.rw),
    .ID_ALUOP(id_c.aluop), .ID_AUIPCLUI(id_c.au),
    .ID_RS1(id_c.rs1), .ID_RS2(id_c.rs2), .ID_RD(id_c.rd),
    .ID_RS2_VALID(id_v), .BRANCH_TAKEN(bt),
    .STALL(STALL), .FLUSH(FLUSH),
    .EX_BRANCH(EX_BRANCH), .EX_MEMREAD(EX_MEMREAD), .EX_MEMTOREG(EX_MEMTOREG),
    .EX_MEMWRITE(EX_MEMWRITE), .EX_ALUSRC(EX_ALUSRC), .EX_REGWRITE(EX_REGWRITE),
    .EX_ALUOP(EX_ALUOP), .EX_AUIPCLUI(EX_AUIPCLUI),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
    .MEM_MEMREAD(MEM_MEMREAD), .MEM_MEMWRITE(MEM_MEMWRITE),
    .MEM_MEMTOREG(MEM_MEMTOREG), .MEM_REGWRITE(MEM_REGWRITE), .MEM_RD(MEM_RD),
    .WB_MEMTOREG(WB_MEMTOREG), .WB_REGWRITE(WB_REGWRITE), .WB_RD(WB_RD),
    .FWD_A(FWD_A), .FWD_B(FWD_B)
  );

  always #5 clk = ~clk;

  // Model: the three instructions currently in EX, MEM and WB.
  ctl_t pipe [3];
  bit   model_ok = 1'b0;
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic ctl_t bubble();
    ctl_t b = '0;
    b.au = 2'b10;
    return b;
  endfunction

  function automatic bit load_use(ctl_t ex, ctl_t id, bit rs2v);
    if (!ex.mr || ex.rd == 0) return 1'b0;
    return (ex.rd == id.rs1) || (rs2v && ex.rd == id.rs2);
  endfunction

  function automatic logic [1:0] fwd(logic [4:0] rs);
    if (pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_edge();
    bit stall_now;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble();
      model_ok = 1'b1;
    end else if (model_ok) begin
      stall_now = load_use(pipe[0], id_c, id_v) && !bt;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (stall_now || bt) ? bubble() : id_c;
    end
  endtask

  task automatic cycle(input ctl_t c, input bit v, input bit b, input bit r);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    id_c = c; id_v = v; bt = b; rst = r;
    if (model_ok) begin
      e.stall = load_use(pipe[0], c, v) && !b;
      e.flush = b;
      e.fa    = fwd(pipe[0].rs1);
      e.fb    = fwd(pipe[0].rs2);
      e.ex    = pipe[0];
      e.mem   = {pipe[1].mr, pipe[1].mw, pipe[1].mt, pipe[1].rw, pipe[1].rd};
      e.wb    = {pipe[2].mt, pipe[2].rw, pipe[2].rd};
      sb.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  exp_t got;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check("stall", 32'(STALL), 32'(got.stall));
      check("flush", 32'(FLUSH), 32'(got.flush));
      check("fwd_a", 32'(FWD_A), 32'(got.fa));
      check("fwd_b", 32'(FWD_B), 32'(got.fb));
      check("ex_stage", 32'({EX_BRANCH, EX_MEMREAD, EX_MEMTOREG, EX_MEMWRITE, EX_ALUSRC,
                             EX_REGWRITE, EX_ALUOP, EX_AUIPCLUI, EX_RS1, EX_RS2, EX_RD}),
            32'(got.ex));
      check("mem_stage", 32'({MEM_MEMREAD, MEM_MEMWRITE, MEM_MEMTOREG, MEM_REGWRITE, MEM_RD}),
            32'(got.mem));
      check("wb_stage", 32'({WB_MEMTOREG, WB_REGWRITE, WB_RD}), 32'(got.wb));
    end
  end

  function automatic ctl_t mk(bit mr, bit mw, bit rw, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    ctl_t c = '0;
    c.mr = mr; c.mt = mr; c.mw = mw; c.rw = rw; c.as = mr | mw;
    c.rs1 = rs1; c.rs2 = rs2; c.rd = rd;
    return c;
  endfunction

  function automatic ctl_t rand_ctl();
    ctl_t c;
    c.br    = ($urandom_range(0, 5) == 0);
    c.mr    = ($urandom_range(0, 2) == 0);
    c.mt    = c.mr;
    c.mw    = ($urandom_range(0, 4) == 0);
    c.as    = 1'($urandom);
    c.rw    = ($urandom_range(0, 3) != 0);
    c.aluop = 3'($urandom);
    c.au    = 2'($urandom);
    c.rs1   = 5'($urandom_range(0, 7));
    c.rs2   = 5'($urandom_range(0, 7));
    c.rd    = 5'($urandom_range(0, 7));
    return c;
  endfunction

  initial begin
    ctl_t nop, r7, lw5, add5, sw, lw3, use3;
    nop  = '0;
    r7   = mk(0, 0, 1, 5'd1, 5'd2, 5'd7);
    lw5  = mk(1, 0, 1, 5'd1, 5'd0, 5'd5);
    add5 = mk(0, 0, 1, 5'd5, 5'd6, 5'd8);
    sw   = mk(0, 1, 0, 5'd2, 5'd3, 5'd0);
    lw3  = mk(1, 0, 1, 5'd2, 5'd0, 5'd3);
    use3 = mk(0, 0, 1, 5'd1, 5'd3, 5'd9);

    id_c = mk(0, 0, 1, 5'd0, 5'd0, 5'd5); id_v = 1'b0; bt = 1'b0; rst = 1'b1;
    cycle(id_c, 0, 0, 1);
    cycle(id_c, 0, 0, 1);

    cycle(r7, 1, 0, 0);
    repeat (4) cycle(nop, 0, 0, 0);

    cycle(lw5, 0, 0, 0);
    cycle(add5, 1, 0, 0);
    cycle(add5, 1, 0, 0);
    repeat (4) cycle(nop, 0, 0, 0);

    cycle(sw, 1, 1, 0);
    repeat (2) cycle(nop, 0, 0, 0);

    cycle(lw3, 0, 0, 0);
    cycle(use3, 1, 1, 0);
    repeat (3) cycle(nop, 0, 0, 0);

    cycle(mk(0, 0, 1, 5'd1, 5'd1, 5'd4), 1, 0, 0);
    cycle(mk(0, 0, 1, 5'd2, 5'd2, 5'd4), 1, 0, 0);
    cycle(mk(0, 0, 1, 5'd4, 5'd4, 5'd1), 1, 0, 0);
    repeat (3) cycle(nop, 0, 0, 0);
    cycle(mk(0, 0, 1, 5'd1, 5'd1, 5'd0), 1, 0, 0);
    cycle(mk(0, 0, 1, 5'd2, 5'd2, 5'd0), 1, 0, 0);
    cycle(mk(0, 0, 1, 5'd0, 5'd0, 5'd1), 1, 0, 0);
    repeat (3) cycle(nop, 0, 0, 0);

    for (int i = 0; i < 600; i++)
      cycle(rand_ctl(), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
